// File: rtl/seq_mag_comparator_pkg.sv
// Shared definitions for the sequential magnitude comparator: FSM encoding
// and the digit-counter width helpers.
package seq_mag_comparator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // A single-digit compare still needs a one-bit counter.
  function automatic int cnt_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/seq_mag_comparator_digit_comp.sv
// Combinational DIGIT-bit magnitude comparator built as an MSB-first
// xnor/and/or prefix chain.
module digit_comp #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  output logic             dgt,
  output logic             deq
);

  logic run_eq;

  // run_eq holds "all higher bits equal" while walking down from the MSB.
  always_comb begin
    dgt    = 1'b0;
    run_eq = 1'b1;
    for (int i = DIGIT - 1; i >= 0; i--) begin
      dgt    = dgt | (run_eq & x[i] & ~y[i]);
      run_eq = run_eq & ~(x[i] ^ y[i]);
    end
    deq = run_eq;
  end

endmodule

// File: rtl/seq_mag_comparator.sv
// Multi-cycle WIDTH-bit magnitude comparator, DIGIT bits per clock, MSB first,
// with optional two's-complement mode and optional early exit.
module seq_mag_comparator
  import seq_mag_comparator_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int DIGIT      = 4,
  parameter int EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  // Handshake: start is taken on any edge where busy is low (IDLE or DONE);
  // busy stays high while digits are processed; done pulses for one cycle and
  // gt/eq/lt are valid from that cycle until the next done.
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_width(N);
  localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

  state_t            state, state_next;
  logic [WIDTH-1:0]  a_sh, b_sh;
  logic [CW-1:0]     cnt;
  logic              decided, gt_f, lt_f;
  logic              dgt, deq;
  logic              accept, last, dec_now, gt_now, lt_now, finish;

  digit_comp #(.DIGIT(DIGIT)) u_digit (
    .x   (a_sh[WIDTH-1 -: DIGIT]),
    .y   (b_sh[WIDTH-1 -: DIGIT]),
    .dgt (dgt),
    .deq (deq)
  );

  assign accept  = start && (state != CMP);
  assign last    = (cnt == CW'(N - 1));
  // The first unequal digit wins; later digits never override it.
  assign dec_now = decided | ~deq;
  assign gt_now  = decided ? gt_f : (~deq & dgt);
  assign lt_now  = decided ? lt_f : (~deq & ~dgt);
  assign finish  = last || ((EARLY_EXIT != 0) && dec_now);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start)  state_next = CMP;
      CMP:     if (finish) state_next = DONE;
      DONE:    state_next = start ? CMP : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == CMP);
    done = (state == DONE);
  end

  // Signed mode flips both sign bits so an unsigned compare orders them correctly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh    <= '0;
      b_sh    <= '0;
      cnt     <= '0;
      decided <= 1'b0;
      gt_f    <= 1'b0;
      lt_f    <= 1'b0;
      gt      <= 1'b0;
      eq      <= 1'b0;
      lt      <= 1'b0;
    end else if (accept) begin
      a_sh    <= signed_mode ? (a ^ MSB_MASK) : a;
      b_sh    <= signed_mode ? (b ^ MSB_MASK) : b;
      cnt     <= '0;
      decided <= 1'b0;
      gt_f    <= 1'b0;
      lt_f    <= 1'b0;
    end else if (state == CMP) begin
      a_sh    <= a_sh << DIGIT;
      b_sh    <= b_sh << DIGIT;
      cnt     <= cnt + 1'b1;
      decided <= dec_now;
      gt_f    <= gt_now;
      lt_f    <= lt_now;
      if (finish) begin
        gt <= gt_now;
        eq <= ~dec_now;
        lt <= lt_now;
      end
    end
  end

endmodule

// File: tb/tb_seq_mag_comparator.sv
// Bench for seq_mag_comparator: one early-exit and one full-length instance
// share stimulus; results are checked against an arithmetic reference model.
module tb_seq_mag_comparator;

  localparam int WIDTH = 16;
  localparam int DIGIT = 4;
  localparam int N     = WIDTH / DIGIT;
  localparam int WIN   = N + 3;

  logic              clk, rst_n, start, signed_mode;
  logic [WIDTH-1:0]  a, b;
  logic [1:0]        busy_v, done_v, gt_v, eq_v, lt_v;  // [1]=early exit, [0]=full run

  int vectors    = 0;
  int miscompares = 0;

  int   first_busy[2], busy_cnt[2], done_cyc[2], done_cnt[2];
  logic rg[2], re[2], rl[2];

  seq_mag_comparator #(.WIDTH(WIDTH), .DIGIT(DIGIT), .EARLY_EXIT(1)) dut_ee (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
    .a(a), .b(b), .busy(busy_v[1]), .done(done_v[1]),
    .gt(gt_v[1]), .eq(eq_v[1]), .lt(lt_v[1])
  );

  seq_mag_comparator #(.WIDTH(WIDTH), .DIGIT(DIGIT), .EARLY_EXIT(0)) dut_full (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
    .a(a), .b(b), .busy(busy_v[0]), .done(done_v[0]),
    .gt(gt_v[0]), .eq(eq_v[0]), .lt(lt_v[0])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: index of the first differing digit (MSB first), N if equal.
  function automatic int exp_k(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
    logic [WIDTH-1:0] x;
    int p;
    x = av ^ bv;
    if (x == 0) return N;
    p = 0;
    for (int i = 0; i < WIDTH; i++) if (x[i]) p = i;
    return N - p / DIGIT;
  endfunction

  // Reference result as {gt, eq, lt}.
  function automatic logic [2:0] exp_rel(input logic [WIDTH-1:0] av,
                                         input logic [WIDTH-1:0] bv, input logic sm);
    int sa, sb;
    if (sm) begin
      sa = $signed(av);
      sb = $signed(bv);
    end else begin
      sa = int'(av);
      sb = int'(bv);
    end
    return {sa > sb, sa == sb, sa < sb};
  endfunction

  task automatic launch(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic sm);
    @(negedge clk);
    a = av;
    b = bv;
    signed_mode = sm;
    start = 1'b1;
  endtask

  // Records busy/done timing of both instances over cycles 1..cycles after a launch.
  task automatic watch(input int cycles);
    for (int i = 0; i < 2; i++) begin
      first_busy[i] = 0; busy_cnt[i] = 0; done_cyc[i] = 0; done_cnt[i] = 0;
      rg[i] = 1'bx; re[i] = 1'bx; rl[i] = 1'bx;
    end
    for (int c = 1; c <= cycles; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      for (int i = 0; i < 2; i++) begin
        if (busy_v[i] === 1'b1) begin
          busy_cnt[i]++;
          if (first_busy[i] == 0) first_busy[i] = c;
        end
        if (done_v[i] === 1'b1) begin
          done_cnt[i]++;
          if (done_cyc[i] == 0) begin
            done_cyc[i] = c;
            rg[i] = gt_v[i]; re[i] = eq_v[i]; rl[i] = lt_v[i];
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({busy_v, done_v, gt_v, eq_v, lt_v} !== 10'b0) begin
      miscompares++;
      $display("FAIL reset_outputs got %b want 0", {busy_v, done_v, gt_v, eq_v, lt_v});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [WIDTH*2:0] tbl [6];
    logic [WIDTH-1:0] av, bv;
    logic sm;
    int kk;
    logic [2:0] er;
    tbl[0] = {16'h1234, 16'h1234, 1'b0};
    tbl[1] = {16'h8000, 16'h7FFF, 1'b0};
    tbl[2] = {16'h8000, 16'h7FFF, 1'b1};
    tbl[3] = {16'h1234, 16'h1235, 1'b0};
    tbl[4] = {16'h0000, 16'hFFFF, 1'b1};
    tbl[5] = {16'h7FFF, 16'h8000, 1'b1};
    for (int t = 0; t < 6; t++) begin
      {av, bv, sm} = tbl[t];
      launch(av, bv, sm);
      watch(WIN);
      er = exp_rel(av, bv, sm);
      for (int i = 0; i < 2; i++) begin
        kk = (i == 1) ? exp_k(av, bv) : N;
        vectors++;
        if (done_cyc[i] != kk + 1 || done_cnt[i] != 1) begin
          miscompares++;
          $display("FAIL dir_done ee=%0d a=%h b=%h s=%0d got cyc %0d cnt %0d want cyc %0d cnt 1",
                   i, av, bv, sm, done_cyc[i], done_cnt[i], kk + 1);
        end
        vectors++;
        if (first_busy[i] != 1 || busy_cnt[i] != kk) begin
          miscompares++;
          $display("FAIL dir_busy ee=%0d a=%h b=%h got first %0d len %0d want first 1 len %0d",
                   i, av, bv, first_busy[i], busy_cnt[i], kk);
        end
        vectors++;
        if ({rg[i], re[i], rl[i]} !== er) begin
          miscompares++;
          $display("FAIL dir_result ee=%0d a=%h b=%h s=%0d got gel %b want %b",
                   i, av, bv, sm, {rg[i], re[i], rl[i]}, er);
        end
      end
    end
  endtask

  task automatic test_ignored_start();
    int dones_first, busy6, second_done;
    logic g5;
    dones_first = 0; busy6 = 0; second_done = 0; g5 = 1'b0;
    launch(16'h0001, 16'h0000, 1'b0);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c <= 5 && done_v[1] === 1'b1) dones_first++;
      if (c == 5) g5 = gt_v[1];
      if (c == 6) busy6 = busy_v[1];
      if (c > 6 && done_v[1] === 1'b1 && second_done == 0) second_done = c;
      case (c)
        1: start = 1'b0;
        2: start = 1'b1;
        3: start = 1'b0;
        5: start = 1'b1;
        6: start = 1'b0;
        default: ;
      endcase
    end
    vectors++;
    if (dones_first != 1 || g5 !== 1'b1) begin
      miscompares++;
      $display("FAIL ignored_start got dones %0d gt %b want dones 1 gt 1", dones_first, g5);
    end
    vectors++;
    if (busy6 != 1 || second_done != 10) begin
      miscompares++;
      $display("FAIL back_to_back got busy6 %0d done_at %0d want busy6 1 done_at 10",
               busy6, second_done);
    end
  endtask

  task automatic test_reset_mid();
    int late_dones;
    late_dones = 0;
    launch(16'h1234, 16'h1234, 1'b0);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (c == 3) rst_n = 1'b0;
      if (c == 4) begin
        vectors++;
        if ({busy_v, done_v, gt_v, eq_v, lt_v} !== 10'b0) begin
          miscompares++;
          $display("FAIL reset_mid got %b want 0", {busy_v, done_v, gt_v, eq_v, lt_v});
        end
        rst_n = 1'b1;
      end
      if (c > 4 && done_v !== 2'b00) late_dones++;
    end
    vectors++;
    if (late_dones != 0) begin
      miscompares++;
      $display("FAIL reset_mid_no_done got %0d done cycles want 0", late_dones);
    end
    launch(16'h00F0, 16'h0F00, 1'b0);
    watch(WIN);
    vectors++;
    if (done_cyc[1] != 3 || {rg[1], re[1], rl[1]} !== 3'b001) begin
      miscompares++;
      $display("FAIL reset_mid_fresh got cyc %0d gel %b want cyc 3 gel 001",
               done_cyc[1], {rg[1], re[1], rl[1]});
    end
  endtask

  task automatic test_random(input int count);
    logic [WIDTH-1:0] av, bv;
    logic sm;
    int kk;
    logic [2:0] er;
    for (int t = 0; t < count; t++) begin
      av = WIDTH'($urandom_range(0, 65535));
      case ($urandom_range(0, 3))
        0:       bv = av;
        1:       bv = av ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
        default: bv = WIDTH'($urandom_range(0, 65535));
      endcase
      sm = 1'($urandom_range(0, 1));
      launch(av, bv, sm);
      watch(WIN);
      er = exp_rel(av, bv, sm);
      for (int i = 0; i < 2; i++) begin
        kk = (i == 1) ? exp_k(av, bv) : N;
        vectors++;
        if (done_cyc[i] != kk + 1 || done_cnt[i] != 1 || busy_cnt[i] != kk ||
            {rg[i], re[i], rl[i]} !== er || $countones({rg[i], re[i], rl[i]}) != 1) begin
          miscompares++;
          $display("FAIL rand ee=%0d a=%h b=%h s=%0d got cyc %0d cnt %0d busy %0d gel %b want cyc %0d cnt 1 busy %0d gel %b",
                   i, av, bv, sm, done_cyc[i], done_cnt[i], busy_cnt[i],
                   {rg[i], re[i], rl[i]}, kk + 1, kk, er);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignored_start();
    test_reset_mid();
    test_random(5000);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
